// File: rtl/mem_write_monitor_if.sv
// Data-memory write port of the single-cycle ARM core, as seen by the monitor.
interface mem_write_monitor_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;

  modport master (output MemWrite, output DataAdr, output WriteData);
  modport slave  (input  MemWrite, input  DataAdr, input  WriteData);
endinterface

// File: rtl/mem_write_monitor.sv
// Watches the core's store port and latches a sticky pass/fail verdict
// together with store/cycle counters and the last store seen.
module mem_write_monitor #(
  parameter logic [31:0] PASS_ADDR    = 32'd100,
  parameter logic [31:0] PASS_DATA    = 32'd7,
  parameter logic [31:0] SCRATCH_ADDR = 32'd96,
  parameter logic [15:0] TIMEOUT      = 16'd1000
) (
  input  logic                      clk,
  input  logic                      reset,
  mem_write_monitor_if.slave        bus,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic [1:0]                fail_code,
  output logic [7:0]                store_count,
  output logic [15:0]               cycle_count,
  output logic [31:0]               last_addr,
  output logic [31:0]               last_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PASSED = 2'd2,
    FAILED = 2'd3
  } state_t;

  localparam logic [1:0]  CODE_NONE    = 2'b00;
  localparam logic [1:0]  CODE_ILLEGAL = 2'b01;
  localparam logic [1:0]  CODE_DATA    = 2'b10;
  localparam logic [1:0]  CODE_TIMEOUT = 2'b11;
  // Timeout fires when the count before this edge is TIMEOUT-1, so the
  // verdict appears after exactly TIMEOUT edges spent in RUN.
  localparam logic [15:0] TIMEOUT_LAST = TIMEOUT - 16'd1;

  state_t       state_q, state_d;
  logic         done_q, done_d;
  logic         pass_q, pass_d;
  logic         fail_q, fail_d;
  logic [1:0]   fail_code_q, fail_code_d;
  logic [7:0]   store_count_q, store_count_d;
  logic [15:0]  cycle_count_q, cycle_count_d;
  logic [31:0]  last_addr_q, last_addr_d;
  logic [31:0]  last_data_q, last_data_d;

  // Next-state, verdict and counter update; terminal states hold everything.
  always_comb begin
    state_d       = state_q;
    done_d        = done_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    fail_code_d   = fail_code_q;
    store_count_d = store_count_q;
    cycle_count_d = cycle_count_q;
    last_addr_d   = last_addr_q;
    last_data_d   = last_data_q;

    case (state_q)
      IDLE: begin
        state_d = RUN;
      end
      RUN: begin
        if (cycle_count_q != 16'hFFFF) begin
          cycle_count_d = cycle_count_q + 16'd1;
        end
        if (bus.MemWrite) begin
          // Stores take precedence over the watchdog in the same cycle.
          if (store_count_q != 8'hFF) begin
            store_count_d = store_count_q + 8'd1;
          end
          last_addr_d = bus.DataAdr;
          last_data_d = bus.WriteData;
          if (bus.DataAdr == PASS_ADDR) begin
            done_d = 1'b1;
            if (bus.WriteData == PASS_DATA) begin
              state_d = PASSED;
              pass_d  = 1'b1;
            end else begin
              state_d     = FAILED;
              fail_d      = 1'b1;
              fail_code_d = CODE_DATA;
            end
          end else if (bus.DataAdr != SCRATCH_ADDR) begin
            state_d     = FAILED;
            done_d      = 1'b1;
            fail_d      = 1'b1;
            fail_code_d = CODE_ILLEGAL;
          end
        end else if (cycle_count_q == TIMEOUT_LAST) begin
          state_d     = FAILED;
          done_d      = 1'b1;
          fail_d      = 1'b1;
          fail_code_d = CODE_TIMEOUT;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // State and output registers; active-low synchronous reset clears all.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      fail_code_q   <= CODE_NONE;
      store_count_q <= 8'd0;
      cycle_count_q <= 16'd0;
      last_addr_q   <= 32'd0;
      last_data_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      fail_code_q   <= fail_code_d;
      store_count_q <= store_count_d;
      cycle_count_q <= cycle_count_d;
      last_addr_q   <= last_addr_d;
      last_data_q   <= last_data_d;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign fail_code   = fail_code_q;
  assign store_count = store_count_q;
  assign cycle_count = cycle_count_q;
  assign last_addr   = last_addr_q;
  assign last_data   = last_data_q;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Directed bench for mem_write_monitor: two instances share one store bus,
// one with the default watchdog (A) and one with TIMEOUT=16 (B).
module tb_mem_write_monitor;

  logic clk = 1'b0;
  logic reset = 1'b0;

  mem_write_monitor_if bus ();

  logic        a_done, a_pass, a_fail;
  logic [1:0]  a_code;
  logic [7:0]  a_sc;
  logic [15:0] a_cc;
  logic [31:0] a_la, a_ld;
  logic        b_done, b_pass, b_fail;
  logic [1:0]  b_code;
  logic [7:0]  b_sc;
  logic [15:0] b_cc;
  logic [31:0] b_la, b_ld;

  mem_write_monitor u_dut_a (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .done(a_done), .pass(a_pass), .fail(a_fail), .fail_code(a_code),
    .store_count(a_sc), .cycle_count(a_cc), .last_addr(a_la), .last_data(a_ld)
  );

  mem_write_monitor #(.TIMEOUT(16'd16)) u_dut_b (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .done(b_done), .pass(b_pass), .fail(b_fail), .fail_code(b_code),
    .store_count(b_sc), .cycle_count(b_cc), .last_addr(b_la), .last_data(b_ld)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          sel_b;
    logic        done, pass, fail;
    logic [1:0]  code;
    logic [7:0]  sc;
    logic [15:0] cc;
    logic [31:0] la, ld;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input bit sel_b, input logic done,
                      input logic pass, input logic fail, input logic [1:0] code,
                      input logic [7:0] sc, input logic [15:0] cc,
                      input logic [31:0] la, input logic [31:0] ld);
    exp_t e;
    e.tag = tag; e.sel_b = sel_b; e.done = done; e.pass = pass; e.fail = fail;
    e.code = code; e.sc = sc; e.cc = cc; e.la = la; e.ld = ld;
    sb_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the selected instance.
  task automatic check();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb_q.pop_front();
    if (e.sel_b) begin
      chk({e.tag, ".done"}, 32'(b_done), 32'(e.done));
      chk({e.tag, ".pass"}, 32'(b_pass), 32'(e.pass));
      chk({e.tag, ".fail"}, 32'(b_fail), 32'(e.fail));
      chk({e.tag, ".code"}, 32'(b_code), 32'(e.code));
      chk({e.tag, ".store_count"}, 32'(b_sc), 32'(e.sc));
      chk({e.tag, ".cycle_count"}, 32'(b_cc), 32'(e.cc));
      chk({e.tag, ".last_addr"}, b_la, e.la);
      chk({e.tag, ".last_data"}, b_ld, e.ld);
    end else begin
      chk({e.tag, ".done"}, 32'(a_done), 32'(e.done));
      chk({e.tag, ".pass"}, 32'(a_pass), 32'(e.pass));
      chk({e.tag, ".fail"}, 32'(a_fail), 32'(e.fail));
      chk({e.tag, ".code"}, 32'(a_code), 32'(e.code));
      chk({e.tag, ".store_count"}, 32'(a_sc), 32'(e.sc));
      chk({e.tag, ".cycle_count"}, 32'(a_cc), 32'(e.cc));
      chk({e.tag, ".last_addr"}, a_la, e.la);
      chk({e.tag, ".last_data"}, a_ld, e.ld);
    end
  endtask

  // Drive one cycle of bus activity and sample 1 time unit after the edge.
  task automatic tick(input logic mw, input logic [31:0] a, input logic [31:0] d);
    bus.MemWrite  = mw;
    bus.DataAdr   = a;
    bus.WriteData = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'd0, 32'd0);
  endtask

  // Hold reset low for n edges, then release; the next edge is the IDLE edge.
  task automatic do_reset(input int n);
    reset = 1'b0;
    bus.MemWrite = 1'b0; bus.DataAdr = 32'd0; bus.WriteData = 32'd0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
    reset = 1'b1;
  endtask

  // Reset, IDLE edge, store (96,5) in RUN cycle 1, (100,7) in RUN cycle 20.
  task automatic golden(input string tag);
    do_reset(2);
    idle(1);
    tick(1'b1, 32'd96, 32'd5);
    idle(18);
    push(tag, 1'b0, 1, 1, 0, 2'b00, 8'd2, 16'd20, 32'd100, 32'd7);
    tick(1'b1, 32'd100, 32'd7);
    check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bus.MemWrite = 1'b0; bus.DataAdr = 32'd0; bus.WriteData = 32'd0;

    // Reset values on both instances.
    do_reset(2);
    push("reset_a", 1'b0, 0, 0, 0, 2'b00, 8'd0, 16'd0, 32'd0, 32'd0);
    check();
    push("reset_b", 1'b1, 0, 0, 0, 2'b00, 8'd0, 16'd0, 32'd0, 32'd0);
    check();

    // Golden path on A; B sees the same bus and its watchdog expires at RUN edge 16.
    golden("golden");
    push("golden_b_timeout", 1'b1, 1, 0, 1, 2'b11, 8'd1, 16'd16, 32'd96, 32'd5);
    check();

    // Sticky: stores to a bad address after pass change nothing.
    for (int i = 0; i < 10; i++) tick(1'b1, 32'd200, 32'd0);
    push("sticky", 1'b0, 1, 1, 0, 2'b00, 8'd2, 16'd20, 32'd100, 32'd7);
    check();

    // One-edge reset after verdict clears everything, then golden passes again.
    bus.MemWrite = 1'b1; bus.DataAdr = 32'd100; bus.WriteData = 32'd7;
    reset = 1'b0;
    @(posedge clk);
    #1;
    push("reset_after_pass", 1'b0, 0, 0, 0, 2'b00, 8'd0, 16'd0, 32'd0, 32'd0);
    check();
    golden("golden_again");

    // Wrong final value.
    do_reset(1);
    idle(1);
    push("wrong_data", 1'b0, 1, 0, 1, 2'b10, 8'd1, 16'd1, 32'd100, 32'd6);
    tick(1'b1, 32'd100, 32'd6);
    check();

    // Illegal address after one scratch store.
    do_reset(1);
    idle(1);
    tick(1'b1, 32'd96, 32'd1);
    push("illegal_addr", 1'b0, 1, 0, 1, 2'b01, 8'd2, 16'd2, 32'd104, 32'd7);
    tick(1'b1, 32'd104, 32'd7);
    check();

    // Timeout on B: nothing after 15 RUN edges, fail on the 16th.
    do_reset(1);
    idle(1);
    idle(15);
    push("timeout_pre", 1'b1, 0, 0, 0, 2'b00, 8'd0, 16'd15, 32'd0, 32'd0);
    check();
    push("timeout", 1'b1, 1, 0, 1, 2'b11, 8'd0, 16'd16, 32'd0, 32'd0);
    idle(1);
    check();

    // Terminating store in the 16th RUN cycle beats the watchdog.
    do_reset(1);
    idle(1);
    idle(15);
    push("store_beats_timeout", 1'b1, 1, 1, 0, 2'b00, 8'd1, 16'd16, 32'd100, 32'd7);
    tick(1'b1, 32'd100, 32'd7);
    check();

    // Saturation on A: 300 scratch stores, then the terminating store.
    do_reset(1);
    idle(1);
    for (int i = 0; i < 300; i++) tick(1'b1, 32'd96, 32'(i));
    push("saturate", 1'b0, 0, 0, 0, 2'b00, 8'd255, 16'd300, 32'd96, 32'd299);
    check();
    push("saturate_pass", 1'b0, 1, 1, 0, 2'b00, 8'd255, 16'd301, 32'd100, 32'd7);
    tick(1'b1, 32'd100, 32'd7);
    check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
